// File: rtl/aes_word_loader.sv
// Word-serial host adapter for an AES-128 core; optional watchdog under `AES_LOADER_WDOG_EN.
// Issue pulse one cycle after the 4th word; ciphertext words stream one per RVALID&RREADY, held while RREADY=0.
module aes_word_loader #(
    parameter int WDOG_CYCLES = 31
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic [31:0]  WDATA,
    input  logic         WSEL,
    input  logic         WVALID,
    output logic         WREADY,
    output logic [31:0]  RDATA,
    output logic         RVALID,
    input  logic         RREADY,
    output logic         ERR,
    output logic [127:0] KIN,
    output logic [127:0] DIN,
    output logic         KRDY,
    output logic         DRDY,
    input  logic         KVLD,
    input  logic         DVLD,
    input  logic [127:0] DOUT,
    input  logic         BSY
);

    typedef enum logic [2:0] {
        IDLE, LOAD, KISSUE, KWAIT, DISSUE, DWAIT, UNLOAD
    } state_t;

    state_t         state_q, state_d;
    logic           blk_type_q, blk_type_d;
    logic [1:0]     cnt_q, cnt_d;
    logic [95:0]    wbuf_q, wbuf_d;
    logic [127:0]   kin_q, kin_d;
    logic [127:0]   din_q, din_d;
    logic           krdy_q, krdy_d;
    logic           drdy_q, drdy_d;
    logic [127:0]   obuf_q, obuf_d;
    logic [1:0]     idx_q, idx_d;
    logic           rvalid_q, rvalid_d;
    logic [31:0]    rdata_q, rdata_d;
    logic           w_acc;
    logic           wdog_expired;

    assign WREADY = ~RST & ((state_q == IDLE) | (state_q == LOAD));
    assign w_acc  = WVALID & WREADY;

    always_comb begin
        state_d    = state_q;
        blk_type_d = blk_type_q;
        cnt_d      = cnt_q;
        wbuf_d     = wbuf_q;
        kin_d      = kin_q;
        din_d      = din_q;
        krdy_d     = 1'b0;
        drdy_d     = 1'b0;
        obuf_d     = obuf_q;
        idx_d      = idx_q;
        rvalid_d   = rvalid_q;
        rdata_d    = rdata_q;
        case (state_q)
            IDLE: begin
                if (w_acc) begin
                    blk_type_d = WSEL;
                    cnt_d      = 2'd1;
                    wbuf_d     = {64'b0, WDATA};
                    state_d    = LOAD;
                end
            end
            LOAD: begin
                if (w_acc) begin
                    // A type change restarts assembly with this word as word 0
                    if (WSEL != blk_type_q) begin
                        blk_type_d = WSEL;
                        cnt_d      = 2'd1;
                        wbuf_d     = {64'b0, WDATA};
                    end else if (cnt_q == 2'd3) begin
                        cnt_d = 2'd0;
                        if (blk_type_q) begin
                            kin_d   = {wbuf_q, WDATA};
                            krdy_d  = 1'b1;
                            state_d = KISSUE;
                        end else begin
                            din_d   = {wbuf_q, WDATA};
                            drdy_d  = ~BSY;
                            state_d = DISSUE;
                        end
                    end else begin
                        cnt_d  = cnt_q + 2'd1;
                        wbuf_d = {wbuf_q[63:0], WDATA};
                    end
                end
            end
            KISSUE: state_d = KWAIT;
            KWAIT: begin
                if (wdog_expired || KVLD) begin
                    state_d = IDLE;
                end
            end
            DISSUE: begin
                // Stay here through the cycle DRDY is high, then wait for the result
                if (wdog_expired) begin
                    state_d = IDLE;
                end else if (drdy_q) begin
                    state_d = DWAIT;
                end else begin
                    drdy_d = ~BSY;
                end
            end
            DWAIT: begin
                if (wdog_expired) begin
                    state_d = IDLE;
                end else if (DVLD) begin
                    obuf_d   = DOUT;
                    rdata_d  = DOUT[127:96];
                    rvalid_d = 1'b1;
                    idx_d    = 2'd0;
                    state_d  = UNLOAD;
                end
            end
            UNLOAD: begin
                if (rvalid_q && RREADY) begin
                    if (idx_q == 2'd3) begin
                        idx_d    = 2'd0;
                        rvalid_d = 1'b0;
                        state_d  = IDLE;
                    end else begin
                        idx_d = idx_q + 2'd1;
                        case (idx_q)
                            2'd0:    rdata_d = obuf_q[95:64];
                            2'd1:    rdata_d = obuf_q[63:32];
                            default: rdata_d = obuf_q[31:0];
                        endcase
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= IDLE;
            blk_type_q <= 1'b0;
            cnt_q      <= 2'd0;
            wbuf_q     <= '0;
            kin_q      <= '0;
            din_q      <= '0;
            krdy_q     <= 1'b0;
            drdy_q     <= 1'b0;
            obuf_q     <= '0;
            idx_q      <= 2'd0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            blk_type_q <= blk_type_d;
            cnt_q      <= cnt_d;
            wbuf_q     <= wbuf_d;
            kin_q      <= kin_d;
            din_q      <= din_d;
            krdy_q     <= krdy_d;
            drdy_q     <= drdy_d;
            obuf_q     <= obuf_d;
            idx_q      <= idx_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
        end
    end

`ifdef AES_LOADER_WDOG_EN
    localparam int WW = $clog2(WDOG_CYCLES + 1);

    logic [WW-1:0] wdog_q, wdog_d;
    logic          err_q, err_d;
    logic          in_wait;

    assign in_wait      = (state_q == KWAIT) | (state_q == DISSUE) | (state_q == DWAIT);
    assign wdog_expired = in_wait & (wdog_q == WW'(WDOG_CYCLES - 1));
    assign err_d        = wdog_expired;

    // Any state change restarts the count, so each wait state is timed from its own entry
    always_comb begin
        wdog_d = wdog_q;
        if (state_d != state_q) begin
            wdog_d = '0;
        end else if (in_wait) begin
            wdog_d = wdog_q + 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wdog_q <= '0;
            err_q  <= 1'b0;
        end else begin
            wdog_q <= wdog_d;
            err_q  <= err_d;
        end
    end

    assign ERR = err_q;
`else
    logic unused_wdog_cfg;

    assign wdog_expired    = 1'b0;
    assign unused_wdog_cfg = ^WDOG_CYCLES;
    assign ERR             = 1'b0;
`endif

    assign KIN    = kin_q;
    assign DIN    = din_q;
    assign KRDY   = krdy_q;
    assign DRDY   = drdy_q;
    assign RVALID = rvalid_q;
    assign RDATA  = rdata_q;

endmodule

// File: tb/tb_aes_word_loader.sv
// Directed-plus-random bench for aes_word_loader with a stub AES core and a block-level reference model.
module tb_aes_word_loader;

    localparam logic [127:0] FIPS_K = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_P = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_C = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         CLK = 1'b0;
    logic         RST;
    logic [31:0]  WDATA;
    logic         WSEL;
    logic         WVALID;
    logic         WREADY;
    logic [31:0]  RDATA;
    logic         RVALID;
    logic         RREADY;
    logic         ERR;
    logic [127:0] KIN;
    logic [127:0] DIN;
    logic         KRDY;
    logic         DRDY;
    logic         KVLD;
    logic         DVLD;
    logic [127:0] DOUT;
    logic         BSY;

    int tests = 0;
    int fails = 0;
    int krdy_cnt = 0;
    int drdy_cnt = 0;
    int err_cnt = 0;
    logic [127:0] key_m;

    aes_word_loader #(.WDOG_CYCLES(31)) dut (
        .CLK(CLK), .RST(RST), .WDATA(WDATA), .WSEL(WSEL), .WVALID(WVALID),
        .WREADY(WREADY), .RDATA(RDATA), .RVALID(RVALID), .RREADY(RREADY),
        .ERR(ERR), .KIN(KIN), .DIN(DIN), .KRDY(KRDY), .DRDY(DRDY),
        .KVLD(KVLD), .DVLD(DVLD), .DOUT(DOUT), .BSY(BSY)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (KRDY) krdy_cnt++;
        if (DRDY) drdy_cnt++;
        if (ERR)  err_cnt++;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout observed=running required=finished");
        $fatal(1, "bench timeout");
    end

    // Stand-in for the cipher: the known FIPS-197 vector, otherwise a keyed scramble
    function automatic logic [127:0] core_fn(input logic [127:0] k, input logic [127:0] d);
        if (k == FIPS_K && d == FIPS_P) return FIPS_C;
        return d ^ {k[63:0], k[127:64]} ^ 128'h5a5a_1234_a5a5_4321_0f0f_9876_f0f0_6789;
    endfunction

    function automatic logic [31:0] wd(input logic [127:0] v, input int i);
        return v[127 - 32*i -: 32];
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic sel, input logic [31:0] d);
        int n = 0;
        WVALID = 1'b1;
        WSEL   = sel;
        WDATA  = d;
        while (!WREADY && n < 50) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 50) chk("wr_timeout", 128'(WREADY), 128'd1);
        @(negedge CLK);
        WVALID = 1'b0;
    endtask

    task automatic load_key(input logic [127:0] k);
        for (int i = 0; i < 4; i++) wr(1'b1, wd(k, i));
        chk("krdy_pulse", 128'(KRDY), 128'd1);
        chk("kin", KIN, k);
        @(negedge CLK);
        chk("krdy_single", 128'(KRDY), 128'd0);
        chk("wready_kwait", 128'(WREADY), 128'd0);
        repeat ($urandom_range(0, 3)) @(negedge CLK);
        KVLD = 1'b1;
        @(negedge CLK);
        KVLD = 1'b0;
        chk("idle_after_kvld", 128'(WREADY), 128'd1);
    endtask

    task automatic issue_data(input logic [127:0] pt, input int bsy_hold);
        for (int i = 0; i < 3; i++) wr(1'b0, wd(pt, i));
        if (bsy_hold > 0) BSY = 1'b1;
        wr(1'b0, wd(pt, 3));
        for (int i = 0; i < bsy_hold; i++) begin
            chk("drdy_while_bsy", 128'(DRDY), 128'd0);
            if (i == bsy_hold - 1) BSY = 1'b0;
            @(negedge CLK);
        end
        chk("drdy_pulse", 128'(DRDY), 128'd1);
        chk("din", DIN, pt);
        @(negedge CLK);
        chk("drdy_single", 128'(DRDY), 128'd0);
    endtask

    task automatic run_data(input logic [127:0] pt, input logic [127:0] exp, input int bsy_hold,
                            input bit bp);
        int st;
        issue_data(pt, bsy_hold);
        repeat ($urandom_range(0, 4)) @(negedge CLK);
        DVLD = 1'b1;
        DOUT = core_fn(KIN, DIN);
        @(negedge CLK);
        DVLD = 1'b0;
        DOUT = rnd128();
        chk("rvalid_first", 128'(RVALID), 128'd1);
        for (int i = 0; i < 4; i++) begin
            st = (bp && i == 1) ? 5 : $urandom_range(0, 2);
            RREADY = 1'b0;
            for (int s = 0; s < st; s++) begin
                chk("hold_rvalid", 128'(RVALID), 128'd1);
                chk("hold_rdata", 128'(RDATA), 128'(wd(exp, i)));
                @(negedge CLK);
            end
            chk("rdata", 128'(RDATA), 128'(wd(exp, i)));
            RREADY = 1'b1;
            @(negedge CLK);
            RREADY = 1'b0;
        end
        chk("rvalid_drop", 128'(RVALID), 128'd0);
        chk("wready_after_unload", 128'(WREADY), 128'd1);
    endtask

    initial begin
        logic [127:0] pt;
        logic [127:0] k;
        int kc;
        int dc;
        int plen;
        bit is_key;

        RST = 1'b1; WDATA = '0; WSEL = 1'b0; WVALID = 1'b0; RREADY = 1'b0;
        KVLD = 1'b0; DVLD = 1'b0; DOUT = '0; BSY = 1'b0;
        key_m = '0;
        repeat (3) @(negedge CLK);
        chk("rst_wready", 128'(WREADY), 128'd0);
        chk("rst_rvalid", 128'(RVALID), 128'd0);
        chk("rst_rdata", 128'(RDATA), 128'd0);
        chk("rst_krdy", 128'(KRDY), 128'd0);
        chk("rst_drdy", 128'(DRDY), 128'd0);
        chk("rst_err", 128'(ERR), 128'd0);
        chk("rst_kin", KIN, 128'd0);
        chk("rst_din", DIN, 128'd0);
        RST = 1'b0;
        #1;
        chk("wready_after_rst", 128'(WREADY), 128'd1);
        @(negedge CLK);

        // Plaintext before any key load runs with the zero key
        pt = rnd128();
        run_data(pt, core_fn(128'd0, pt), 0, 1'b0);

        load_key(FIPS_K);
        key_m = FIPS_K;
        run_data(FIPS_P, FIPS_C, 0, 1'b0);

        pt = rnd128();
        run_data(pt, core_fn(key_m, pt), 0, 1'b1);

        // Partial plaintext superseded by a key block
        kc = krdy_cnt;
        dc = drdy_cnt;
        wr(1'b0, $urandom);
        wr(1'b0, $urandom);
        k = rnd128();
        load_key(k);
        key_m = k;
        chk("switch_no_drdy", 128'(drdy_cnt), 128'(dc));
        chk("switch_one_krdy", 128'(krdy_cnt), 128'(kc + 1));

        pt = rnd128();
        run_data(pt, core_fn(key_m, pt), 3, 1'b0);

        // Strobes from the core while idle must not start a readout
        KVLD = 1'b1;
        DVLD = 1'b1;
        DOUT = rnd128();
        @(negedge CLK);
        KVLD = 1'b0;
        DVLD = 1'b0;
        @(negedge CLK);
        chk("stray_rvalid", 128'(RVALID), 128'd0);
        chk("stray_wready", 128'(WREADY), 128'd1);

        for (int it = 0; it < 6; it++) begin
            is_key = 1'($urandom_range(0, 1));
            plen = $urandom_range(0, 3);
            for (int p = 0; p < plen; p++) wr(~is_key, $urandom);
            if (is_key) begin
                k = rnd128();
                load_key(k);
                key_m = k;
            end else begin
                pt = rnd128();
                run_data(pt, core_fn(key_m, pt), 0, 1'b0);
            end
        end

`ifdef AES_LOADER_WDOG_EN
        issue_data(rnd128(), 0);
        for (int i = 0; i < 31; i++) begin
            chk("wdog_err_early", 128'(ERR), 128'd0);
            @(negedge CLK);
        end
        chk("wdog_err_pulse", 128'(ERR), 128'd1);
        chk("wdog_idle", 128'(WREADY), 128'd1);
        @(negedge CLK);
        chk("wdog_err_single", 128'(ERR), 128'd0);
        chk("wdog_err_total", 128'(err_cnt), 128'd1);
`else
        chk("err_tied_low", 128'(err_cnt), 128'd0);
`endif

        // Reset in the middle of a readout
        pt = rnd128();
        issue_data(pt, 0);
        DVLD = 1'b1;
        DOUT = core_fn(KIN, DIN);
        @(negedge CLK);
        DVLD = 1'b0;
        chk("unload_rvalid", 128'(RVALID), 128'd1);
        chk("unload_rdata0", 128'(RDATA), 128'(wd(core_fn(key_m, pt), 0)));
        RREADY = 1'b1;
        @(negedge CLK);
        RREADY = 1'b0;
        RST = 1'b1;
        #1;
        chk("midrst_rvalid", 128'(RVALID), 128'd0);
        chk("midrst_rdata", 128'(RDATA), 128'd0);
        chk("midrst_wready", 128'(WREADY), 128'd0);
        chk("midrst_kin", KIN, 128'd0);
        @(negedge CLK);
        RST = 1'b0;
        kc = krdy_cnt;
        dc = drdy_cnt;
        repeat (4) @(negedge CLK);
        chk("postrst_no_krdy", 128'(krdy_cnt), 128'(kc));
        chk("postrst_no_drdy", 128'(drdy_cnt), 128'(dc));
        chk("postrst_rvalid", 128'(RVALID), 128'd0);
        chk("postrst_wready", 128'(WREADY), 128'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
